// File: rtl/loop_counter_cfg_axil_slave.sv
// AXI4-Lite register slave (CTRL/PERIOD/NLOOPS/STATUS) that also runs the DRX loop counter.
// Optional level interrupt enabled by defining LOOP_COUNTER_CFG_IRQ_EN.
module loop_counter_cfg_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            loop_tick,
  output logic                            loop_active,
  output logic                            irq
);

  logic        rstDone_q;
  logic        awFull_q, awFull_d;
  logic [1:0]  awIdx_q, awIdx_d;
  logic        wFull_q, wFull_d;
  logic [31:0] wData_q, wData_d;
  logic [3:0]  wStrb_q, wStrb_d;
  logic        bvalid_q, bvalid_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;

  logic        ctrlEn_q, ctrlEn_d;
  logic [31:0] period_q, period_d;
  logic [31:0] nloops_q, nloops_d;
  logic        done_q, done_d;
  logic [31:0] cnt_q, cnt_d;
  logic [30:0] index_q, index_d;
  logic        tick_q, tick_d;
  logic        active_q, active_d;

  logic        awHs, wHs, arHs, commit, ctrlWrite, doneClr, ctrlIrqBit;
  logic [1:0]  wrIdx;
  logic [31:0] wrData, readMux;
  logic [3:0]  wrStrb;
  logic [30:0] indexInc;
  logic        unusedOk;

  assign unusedOk = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  function automatic logic [31:0] applyStrb(input logic [31:0] oldVal, input logic [31:0] newVal,
                                            input logic [3:0] strb);
    logic [31:0] res;
    res = oldVal;
    for (int b = 0; b < 4; b++)
      if (strb[b]) res[8*b +: 8] = newVal[8*b +: 8];
    return res;
  endfunction

  // Readies stay low until the first edge after reset release.
  assign S_AXI_AWREADY = rstDone_q & ~awFull_q & ~bvalid_q;
  assign S_AXI_WREADY  = rstDone_q & ~wFull_q & ~bvalid_q;
  assign S_AXI_ARREADY = rstDone_q & ~rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign loop_tick     = tick_q;
  assign loop_active   = active_q;

  assign awHs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign wHs  = S_AXI_WVALID & S_AXI_WREADY;
  assign arHs = S_AXI_ARVALID & S_AXI_ARREADY;

  // A fresh handshake bypasses its buffer so a same-cycle AW+W pair commits at once.
  assign wrIdx     = awFull_q ? awIdx_q : S_AXI_AWADDR[3:2];
  assign wrData    = wFull_q ? wData_q : S_AXI_WDATA;
  assign wrStrb    = wFull_q ? wStrb_q : S_AXI_WSTRB;
  assign commit    = (awFull_q | awHs) & (wFull_q | wHs);
  assign ctrlWrite = commit & (wrIdx == 2'd0) & wrStrb[0];
  assign doneClr   = ctrlWrite & wrData[1];
  assign indexInc  = index_q + 31'd1;

  always_comb begin
    readMux = 32'h0;
    case (S_AXI_ARADDR[3:2])
      2'd0: readMux = {29'h0, ctrlIrqBit, 1'b0, ctrlEn_q};
      2'd1: readMux = period_q;
      2'd2: readMux = nloops_q;
      default: readMux = {done_q, index_q};
    endcase
  end

  always_comb begin
    awFull_d = awFull_q;
    awIdx_d  = awIdx_q;
    wFull_d  = wFull_q;
    wData_d  = wData_q;
    wStrb_d  = wStrb_q;
    bvalid_d = bvalid_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (commit) begin
      awFull_d = 1'b0;
      wFull_d  = 1'b0;
      bvalid_d = 1'b1;
    end else begin
      if (awHs) begin
        awFull_d = 1'b1;
        awIdx_d  = S_AXI_AWADDR[3:2];
      end
      if (wHs) begin
        wFull_d = 1'b1;
        wData_d = S_AXI_WDATA;
        wStrb_d = S_AXI_WSTRB;
      end
      if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
    end
    if (arHs) begin
      rvalid_d = 1'b1;
      rdata_d  = readMux;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  // Register writes and the counter; a clearing EN write overrides a wrap on the same edge.
  always_comb begin
    ctrlEn_d = ctrlEn_q;
    period_d = period_q;
    nloops_d = nloops_q;
    if (ctrlWrite) ctrlEn_d = wrData[0];
    if (commit && wrIdx == 2'd1) period_d = applyStrb(period_q, wrData, wrStrb);
    if (commit && wrIdx == 2'd2) nloops_d = applyStrb(nloops_q, wrData, wrStrb);

    cnt_d   = cnt_q;
    index_d = index_q;
    done_d  = done_q;
    tick_d  = 1'b0;
    if (!ctrlEn_d || doneClr) begin
      cnt_d   = 32'h0;
      index_d = 31'h0;
      if (doneClr) done_d = 1'b0;
    end else if (ctrlEn_q && !done_q) begin
      if (cnt_q >= period_q) begin
        cnt_d   = 32'h0;
        tick_d  = 1'b1;
        index_d = indexInc;
        if (nloops_q != 32'h0 && {1'b0, indexInc} == nloops_q) done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
    active_d = ctrlEn_d & ~done_d;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rstDone_q <= 1'b0;
      awFull_q  <= 1'b0;
      awIdx_q   <= 2'h0;
      wFull_q   <= 1'b0;
      wData_q   <= 32'h0;
      wStrb_q   <= 4'h0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
      ctrlEn_q  <= 1'b0;
      period_q  <= 32'h0;
      nloops_q  <= 32'h0;
      done_q    <= 1'b0;
      cnt_q     <= 32'h0;
      index_q   <= 31'h0;
      tick_q    <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      rstDone_q <= 1'b1;
      awFull_q  <= awFull_d;
      awIdx_q   <= awIdx_d;
      wFull_q   <= wFull_d;
      wData_q   <= wData_d;
      wStrb_q   <= wStrb_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      ctrlEn_q  <= ctrlEn_d;
      period_q  <= period_d;
      nloops_q  <= nloops_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      index_q   <= index_d;
      tick_q    <= tick_d;
      active_q  <= active_d;
    end
  end

`ifdef LOOP_COUNTER_CFG_IRQ_EN
  logic ctrlIrqEn_q, ctrlIrqEn_d, irq_q;

  always_comb begin
    ctrlIrqEn_d = ctrlIrqEn_q;
    if (ctrlWrite) ctrlIrqEn_d = wrData[2];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ctrlIrqEn_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      ctrlIrqEn_q <= ctrlIrqEn_d;
      irq_q       <= done_d & ctrlIrqEn_d;
    end
  end

  assign ctrlIrqBit = ctrlIrqEn_q;
  assign irq        = irq_q;
`else
  assign ctrlIrqBit = 1'b0;
  assign irq        = 1'b0;
`endif

endmodule

// File: tb/tb_loop_counter_cfg_axil_slave.sv
// Self-checking bench for loop_counter_cfg_axil_slave: register vector table plus counter sequences.
module tb_loop_counter_cfg_axil_slave;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [3:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [3:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic        loop_tick;
  logic        loop_active;
  logic        irq;

`ifdef LOOP_COUNTER_CFG_IRQ_EN
  localparam logic [31:0] IRQ_BIT = 32'h4;
  localparam logic        EXP_IRQ = 1'b1;
`else
  localparam logic [31:0] IRQ_BIT = 32'h0;
  localparam logic        EXP_IRQ = 1'b0;
`endif

  typedef struct {
    bit          isWrite;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] expData;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] expQ[$];
  int          checks = 0;
  int          failures = 0;

  loop_counter_cfg_axil_slave dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .loop_tick(loop_tick), .loop_active(loop_active), .irq(irq)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checkOutput(name, {31'h0, actual}, {31'h0, expected});
  endtask

  task automatic tick1();
    @(posedge ACLK);
    #1;
  endtask

  task automatic axiWrite(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input string name, output logic tickAtB);
    int n;
    bit awDone, wDone, awHs, wHs;
    S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
    S_AXI_BREADY = 1'b0;
    awDone = 1'b0; wDone = 1'b0; n = 0;
    while (!(awDone && wDone) && n < 20) begin
      awHs = S_AXI_AWVALID && S_AXI_AWREADY;
      wHs  = S_AXI_WVALID && S_AXI_WREADY;
      tick1();
      if (awHs) begin S_AXI_AWVALID = 1'b0; awDone = 1'b1; end
      if (wHs) begin S_AXI_WVALID = 1'b0; wDone = 1'b1; end
      n++;
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    checkBit({name, "_awwHandshake"}, awDone && wDone, 1'b1);
    n = 0;
    while (!S_AXI_BVALID && n < 20) begin tick1(); n++; end
    checkBit({name, "_bvalid"}, S_AXI_BVALID, 1'b1);
    checkOutput({name, "_bresp"}, {30'h0, S_AXI_BRESP}, 32'h0);
    tickAtB = loop_tick;
    S_AXI_BREADY = 1'b1;
    tick1();
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic writeReg(input logic [3:0] addr, input logic [31:0] data, input string name);
    logic unusedTick;
    axiWrite(addr, data, 4'hF, name, unusedTick);
  endtask

  task automatic readReg(input logic [3:0] addr, input logic [31:0] expData, input string name);
    int n;
    bit arHs;
    logic [31:0] want;
    expQ.push_back(expData);
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    arHs = 1'b0; n = 0;
    while (!arHs && n < 20) begin
      arHs = S_AXI_ARREADY;
      tick1();
      n++;
    end
    S_AXI_ARVALID = 1'b0;
    checkBit({name, "_arHandshake"}, arHs, 1'b1);
    n = 0;
    while (!S_AXI_RVALID && n < 20) begin tick1(); n++; end
    checkBit({name, "_rvalid"}, S_AXI_RVALID, 1'b1);
    want = expQ.pop_front();
    checkOutput(name, S_AXI_RDATA, want);
    checkOutput({name, "_rresp"}, {30'h0, S_AXI_RRESP}, 32'h0);
    S_AXI_RREADY = 1'b1;
    tick1();
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic unusedTick;
    if (v.isWrite) axiWrite(v.addr, v.data, v.strb, $sformatf("vec%0d_wr", idx), unusedTick);
    else           readReg(v.addr, v.expData, $sformatf("vec%0d_rd", idx));
  endtask

  initial begin
    int tickCount, firstTick, secondTick;
    logic tickAtB;

    ARESETN = 1'b0;
    S_AXI_AWADDR = 4'h0; S_AXI_AWPROT = 3'h0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'h0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = 4'h0; S_AXI_ARPROT = 3'h0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;

    #190;
    checkOutput("resetReadies", {29'h0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'h0);
    checkOutput("resetValids", {30'h0, S_AXI_BVALID, S_AXI_RVALID}, 32'h0);
    checkOutput("resetLoopOuts", {29'h0, loop_tick, loop_active, irq}, 32'h0);
    checkOutput("resetRdata", S_AXI_RDATA, 32'h0);
    #10 ARESETN = 1'b1;
    tick1();
    checkOutput("readiesAfterReset", {29'h0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'h7);

    vecs.push_back('{1'b1, 4'h4, 32'h0000_0002, 4'hF, 32'h0});
    vecs.push_back('{1'b1, 4'h8, 32'h0000_0003, 4'hF, 32'h0});
    vecs.push_back('{1'b1, 4'hC, 32'h0000_0004, 4'hF, 32'h0});
    vecs.push_back('{1'b0, 4'hC, 32'h0, 4'h0, 32'h0000_0000});
    vecs.push_back('{1'b0, 4'h4, 32'h0, 4'h0, 32'h0000_0002});
    vecs.push_back('{1'b0, 4'h8, 32'h0, 4'h0, 32'h0000_0003});
    vecs.push_back('{1'b1, 4'h4, 32'h0000_0000, 4'hF, 32'h0});
    vecs.push_back('{1'b1, 4'h4, 32'hAABB_CCDD, 4'b0010, 32'h0});
    vecs.push_back('{1'b0, 4'h4, 32'h0, 4'h0, 32'h0000_CC00});
    vecs.push_back('{1'b1, 4'h8, 32'h1122_3344, 4'b1001, 32'h0});
    vecs.push_back('{1'b0, 4'h8, 32'h0, 4'h0, 32'h1100_0044});
    vecs.push_back('{1'b1, 4'h0, 32'hFFFF_FFFF, 4'b1110, 32'h0});
    vecs.push_back('{1'b0, 4'h0, 32'h0, 4'h0, 32'h0000_0000});
    vecs.push_back('{1'b1, 4'h0, 32'h0000_0004, 4'hF, 32'h0});
    vecs.push_back('{1'b0, 4'h0, 32'h0, 4'h0, IRQ_BIT});
    vecs.push_back('{1'b1, 4'h0, 32'h0000_0000, 4'hF, 32'h0});
    vecs.push_back('{1'b1, 4'h8, 32'h0000_0003, 4'hF, 32'h0});
    vecs.push_back('{1'b1, 4'h4, 32'h0000_0002, 4'hF, 32'h0});
    vecs.push_back('{1'b1, 4'h0, 32'h0000_0001, 4'hF, 32'h0});
    vecs.push_back('{1'b0, 4'h0, 32'h0, 4'h0, 32'h0000_0001});
    vecs.push_back('{1'b0, 4'h4, 32'h0, 4'h0, 32'h0000_0002});
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    // PERIOD=2, NLOOPS=3 run finishes with index 3; EN=0 clears index but keeps DONE.
    repeat (30) tick1();
    checkBit("activeAfterDone", loop_active, 1'b0);
    readReg(4'hC, 32'h8000_0003, "statusDone3");
    writeReg(4'h0, 32'h0, "ctrlDisable");
    readReg(4'hC, 32'h8000_0000, "statusDoneKept");
    writeReg(4'h0, 32'h2, "ctrlDoneClr");
    readReg(4'hC, 32'h0, "statusCleared");

    // Same-cycle read and write of PERIOD returns the old value.
    checkOutput("simulReadies", {29'h0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'h7);
    expQ.push_back(32'h0000_0002);
    S_AXI_AWADDR = 4'h4; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h7; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 4'h4; S_AXI_ARVALID = 1'b1;
    tick1();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    checkOutput("simulValids", {30'h0, S_AXI_BVALID, S_AXI_RVALID}, 32'h3);
    checkOutput("simulOldData", S_AXI_RDATA, expQ.pop_front());
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    tick1();
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    readReg(4'h4, 32'h7, "simulNewData");

    // AW in cycle 0, W in cycle 3, BVALID from cycle 4, BREADY withheld for 5 cycles.
    S_AXI_AWADDR = 4'h4; S_AXI_AWVALID = 1'b1;
    checkBit("skewAwready0", S_AXI_AWREADY, 1'b1);
    tick1();
    S_AXI_AWVALID = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      checkOutput($sformatf("skewC%0d", c), {29'h0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 32'h2);
      if (c == 3) begin
        S_AXI_WDATA = 32'h5; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      end
      tick1();
    end
    S_AXI_WVALID = 1'b0;
    for (int c = 4; c <= 8; c++) begin
      checkOutput($sformatf("skewHoldC%0d", c), {29'h0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 32'h1);
      tick1();
    end
    S_AXI_BREADY = 1'b1;
    tick1();
    S_AXI_BREADY = 1'b0;
    checkOutput("skewReleased", {29'h0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 32'h6);
    readReg(4'h4, 32'h5, "skewPeriod");

    // PERIOD=3, NLOOPS=2: two ticks four cycles apart, then DONE.
    writeReg(4'h4, 32'h3, "cntPeriod");
    writeReg(4'h8, 32'h2, "cntNloops");
    writeReg(4'h0, 32'h5, "cntCtrl");
    tickCount = 0; firstTick = -1; secondTick = -1;
    for (int c = 0; c < 40; c++) begin
      if (loop_tick) begin
        if (tickCount == 0) begin
          firstTick = c;
          checkBit("cntActiveRunning", loop_active, 1'b1);
        end else if (tickCount == 1) begin
          secondTick = c;
        end
        tickCount++;
      end
      tick1();
    end
    checkOutput("cntTickCount", tickCount, 32'd2);
    checkOutput("cntTickGap", secondTick - firstTick, 32'd4);
    checkBit("cntActiveDone", loop_active, 1'b0);
    checkBit("cntIrqDone", irq, EXP_IRQ);
    readReg(4'hC, 32'h8000_0002, "cntStatus");
    readReg(4'h0, 32'h1 | IRQ_BIT, "cntCtrlRead");
    writeReg(4'h0, 32'h6, "cntDoneClr");
    checkBit("cntIrqCleared", irq, 1'b0);
    readReg(4'hC, 32'h0, "cntStatusCleared");

    // NLOOPS=0, PERIOD=0: tick every cycle until EN=0, which suppresses the tick on its edge.
    writeReg(4'h4, 32'h0, "fwdPeriod");
    writeReg(4'h8, 32'h0, "fwdNloops");
    writeReg(4'h0, 32'h1, "fwdEnable");
    for (int c = 0; c < 8; c++) begin
      checkBit($sformatf("fwdTick%0d", c), loop_tick, 1'b1);
      tick1();
    end
    checkBit("fwdActive", loop_active, 1'b1);
    axiWrite(4'h0, 32'h0, 4'hF, "fwdDisable", tickAtB);
    checkBit("fwdNoTickOnDisable", tickAtB, 1'b0);
    checkBit("fwdTickAfter", loop_tick, 1'b0);
    checkBit("fwdActiveAfter", loop_active, 1'b0);
    readReg(4'hC, 32'h0, "fwdStatus");

    // Reset while a write response and a read response are pending.
    S_AXI_AWADDR = 4'h0; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h1; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 4'h4; S_AXI_ARVALID = 1'b1;
    tick1();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    checkOutput("midPending", {30'h0, S_AXI_BVALID, S_AXI_RVALID}, 32'h3);
    tick1();
    ARESETN = 1'b0;
    #1;
    checkOutput("midResetValids", {30'h0, S_AXI_BVALID, S_AXI_RVALID}, 32'h0);
    checkOutput("midResetReadies", {29'h0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'h0);
    checkBit("midResetActive", loop_active, 1'b0);
    #20 ARESETN = 1'b1;
    tick1();
    readReg(4'h0, 32'h0, "midCtrlReset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
